// File: rtl/mouse_pos_latch.sv
// ----------------------------------------------------------------------------
// mouse_pos_latch
//
// Frame-synchronous mouse front end for the cursor overlay stage.
//   - Position samples from the mouse controller are clamped to the visible
//     area and parked in pending registers. They are copied to x_start/y_start
//     only at the start of vertical blanking, so the cursor never tears.
//   - The raw left button is synchronized and debounced by a four-state FSM.
//     This produces a one-cycle click pulse and a debounced held level.
//
// Ports:
//   clk65MHz     in   1  pixel clock, the only clock
//   rst_n        in   1  asynchronous active-low reset
//   mouse_xpos   in  12  raw x from the mouse controller (unsigned)
//   mouse_ypos   in  12  raw y from the mouse controller (unsigned)
//   mouse_valid  in   1  one-cycle strobe qualifying xpos/ypos
//   mouse_left   in   1  raw left button level (asynchronous, bouncy)
//   vblnk        in   1  vertical blank from the VGA timing chain
//   x_start      out 12  registered cursor x, frame-stable
//   y_start      out 12  registered cursor y, frame-stable
//   pos_updated  out  1  one-cycle pulse after x_start/y_start reload
//   left_click   out  1  one-cycle pulse on an accepted press
//   left_held    out  1  debounced button level
// ----------------------------------------------------------------------------
module mouse_pos_latch #(
    parameter int X_MAX           = 1023,
    parameter int Y_MAX           = 767,
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic        clk65MHz,
    input  logic        rst_n,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_valid,
    input  logic        mouse_left,
    input  logic        vblnk,
    output logic [11:0] x_start,
    output logic [11:0] y_start,
    output logic        pos_updated,
    output logic        left_click,
    output logic        left_held
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [11:0]      X_LIM    = 12'(X_MAX);
    localparam logic [11:0]      Y_LIM    = 12'(Y_MAX);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } db_state_t;

    // Unsigned 12-bit saturation to an upper limit.
    function automatic logic [11:0] clamp12(input logic [11:0] v, input logic [11:0] lim);
        clamp12 = (v > lim) ? lim : v;
    endfunction

    logic        vblnk_d_r;
    logic        frame_start_s;
    logic [11:0] pend_x_r;
    logic [11:0] pend_y_r;
    logic        pending_r;
    logic [11:0] stage_x_r;
    logic [11:0] stage_y_r;
    logic        load_r;

    logic        sync1_r;
    logic        btn_sync_r;
    db_state_t   state_r;
    db_state_t   next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic        click_next_s;
    logic        held_next_s;

    assign frame_start_s = vblnk & ~vblnk_d_r;

    // Capture clamped samples; snapshot them at frame start so a sample
    // arriving on that same cycle is kept for the next frame.
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_d_r <= 1'b0;
            pend_x_r  <= 12'd0;
            pend_y_r  <= 12'd0;
            pending_r <= 1'b0;
            stage_x_r <= 12'd0;
            stage_y_r <= 12'd0;
            load_r    <= 1'b0;
        end else begin
            vblnk_d_r <= vblnk;
            load_r    <= frame_start_s & pending_r;
            if (frame_start_s && pending_r) begin
                stage_x_r <= pend_x_r;
                stage_y_r <= pend_y_r;
            end
            if (mouse_valid) begin
                pend_x_r  <= clamp12(mouse_xpos, X_LIM);
                pend_y_r  <= clamp12(mouse_ypos, Y_LIM);
                pending_r <= 1'b1;
            end else if (frame_start_s && pending_r) begin
                pending_r <= 1'b0;
            end
        end
    end

    // Frame-stable position outputs and their update pulse.
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            x_start     <= 12'd0;
            y_start     <= 12'd0;
            pos_updated <= 1'b0;
        end else begin
            pos_updated <= load_r;
            if (load_r) begin
                x_start <= stage_x_r;
                y_start <= stage_y_r;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r    <= 1'b0;
            btn_sync_r <= 1'b0;
        end else begin
            sync1_r    <= mouse_left;
            btn_sync_r <= sync1_r;
        end
    end

    // Debounce FSM next-state, counter and click decode.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        click_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (btn_sync_r) begin
                    next_state_s = DB_PRESS;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    next_state_s = IDLE;
                end
            end
            DB_PRESS: begin
                if (!btn_sync_r) begin
                    next_state_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    next_state_s = PRESSED;
                    click_next_s = 1'b1;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_sync_r) begin
                    next_state_s = DB_RELEASE;
                    cnt_next_s   = {CNT_W{1'b0}};
                end else begin
                    next_state_s = PRESSED;
                end
            end
            DB_RELEASE: begin
                if (btn_sync_r) begin
                    next_state_s = PRESSED;
                end else if (cnt_r == CNT_LAST) begin
                    next_state_s = IDLE;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                next_state_s = IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
        // Held covers the final DB_RELEASE cycle as well, so the level drops
        // one edge after the FSM is back in IDLE.
        held_next_s = (next_state_s == PRESSED) || (next_state_s == DB_RELEASE) ||
                      (state_r == DB_RELEASE);
    end

    // Debounce FSM state, counter and registered button outputs.
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            left_click <= 1'b0;
            left_held  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            cnt_r      <= cnt_next_s;
            left_click <= click_next_s;
            left_held  <= held_next_s;
        end
    end

endmodule
